// File: rtl/chinpo_pkg.sv
// rtl/chinpo_pkg.sv - shared state, opcode and datapath-select encodings for the CHINPO control unit
package chinpo_pkg;

    typedef enum logic [4:0] {
        ST_RESET     = 5'd0,
        ST_FETCH     = 5'd1,
        ST_DECODE    = 5'd2,
        ST_DR        = 5'd3,
        ST_IMM       = 5'd4,
        ST_MEMADDR   = 5'd5,
        ST_BEQ       = 5'd6,
        ST_J         = 5'd7,
        ST_JR        = 5'd8,
        ST_DR_WRITE  = 5'd9,
        ST_SW_WRITE  = 5'd10,
        ST_LW_READ   = 5'd11,
        ST_LW_WRITE  = 5'd12,
        ST_JAL       = 5'd13,
        ST_INTERRUPT = 5'd14,
        ST_FAULT     = 5'd15
    } state_t;

    localparam logic [3:0] OP_JR      = 4'd3;
    localparam logic [3:0] OP_IMM_4   = 4'd4;
    localparam logic [3:0] OP_J       = 4'd8;
    localparam logic [3:0] OP_IMM_9   = 4'd9;
    localparam logic [3:0] OP_IMM_10  = 4'd10;
    localparam logic [3:0] OP_JAL     = 4'd11;
    localparam logic [3:0] OP_BEQ     = 4'd12;
    localparam logic [3:0] OP_IMM_13  = 4'd13;
    localparam logic [3:0] OP_LW      = 4'd14;
    localparam logic [3:0] OP_SW      = 4'd15;

    localparam logic [1:0] ALUOP_FUNC = 2'd2;
    localparam logic [1:0] ALUOP_PASS = 2'd3;

    localparam logic [1:0] PCIN_JUMP  = 2'd1;
    localparam logic [1:0] PCIN_VEC   = 2'd3;

    localparam logic [1:0] MADDR_ALU  = 2'd1;
    localparam logic [1:0] MADDR_VEC  = 2'd3;

    localparam logic [2:0] SRCB_IMM   = 3'd1;
    localparam logic [2:0] SRCB_OFFS  = 3'd3;
    localparam logic [2:0] SRCB_FOUR  = 3'd4;

    // Memory states are the only ones that stall on MemReady.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_SW_WRITE) ||
               (s == ST_LW_READ) || (s == ST_INTERRUPT);
    endfunction

endpackage

// File: rtl/chinpo_irq_prio.sv
// rtl/chinpo_irq_prio.sv - lowest-index-first interrupt priority encoder
module chinpo_irq_prio #(
    parameter int NUM_IRQ = 4,
    parameter int VEC_W   = 2
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [VEC_W-1:0]   index,
    output logic [NUM_IRQ-1:0] onehot
);

    always_comb begin
        valid  = |req;
        index  = '0;
        onehot = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index     = VEC_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chinpo_control_mc.sv
// rtl/chinpo_control_mc.sv - multicycle CHINPO controller with wait states and prioritised interrupts
// Optional memory-timeout fault enabled by defining CHINPO_CTRL_MEM_TIMEOUT_EN.
module chinpo_control_mc
    import chinpo_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int NUM_IRQ      = 4,
    parameter int MEM_WAIT_MAX = 15,
    localparam int VEC_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Branch,
    input  logic [3:0]          IR,
    input  logic [NUM_IRQ-1:0]  IrqReq,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemData,
    output logic                ALUSrcA,
    output logic                WriteDataSrc,
    output logic                CLRA,
    output logic                CLRB,
    output logic                MVA,
    output logic                MVB,
    output logic [2:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          MemAddr,
    output logic [1:0]          PcIn,
    output logic [NUM_IRQ-1:0]  IrqAck,
    output logic [VEC_W-1:0]    IrqVector,
    output logic                MemFault,
    output logic [4:0]          CurrentState
);

    state_t               state_q, state_d, state_n;
    logic                 ie_q;
    logic [NUM_IRQ-1:0]   irq_onehot_q;
    logic                 irq_valid;
    logic [VEC_W-1:0]     irq_index;
    logic [NUM_IRQ-1:0]   irq_onehot;
    logic                 at_boundary, enter_irq, irq_taken, set_ie;
    logic                 op_legal;
    logic [3:0]           op4;

    chinpo_irq_prio #(
        .NUM_IRQ (NUM_IRQ),
        .VEC_W   (VEC_W)
    ) u_irq_prio (
        .req    (IrqReq),
        .valid  (irq_valid),
        .index  (irq_index),
        .onehot (irq_onehot)
    );

    // Opcodes wider than the 4-bit ISA decode as NOP.
    assign op_legal     = (Opcode >> 4) == '0;
    assign op4          = Opcode[3:0];
    assign CurrentState = state_q;

    always_comb begin
        state_d      = state_q;
        at_boundary  = 1'b0;
        enter_irq    = 1'b0;
        irq_taken    = 1'b0;
        set_ie       = 1'b0;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemData      = 1'b0;
        ALUSrcA      = 1'b0;
        WriteDataSrc = 1'b0;
        CLRA         = 1'b0;
        CLRB         = 1'b0;
        MVA          = 1'b0;
        MVB          = 1'b0;
        ALUSrcB      = 3'd0;
        ALUOp        = 2'd0;
        MemAddr      = 2'd0;
        PcIn         = 2'd0;
        IrqAck       = '0;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_OFFS;
                if (!op_legal) begin
                    at_boundary = 1'b1;
                end else begin
                    case (op4)
                        OP_JR:                                    state_d = ST_JR;
                        OP_IMM_4, OP_IMM_9, OP_IMM_10, OP_IMM_13: state_d = ST_IMM;
                        OP_J, OP_JAL:                             state_d = ST_J;
                        OP_LW, OP_SW:                             state_d = ST_MEMADDR;
                        OP_BEQ: begin
                            if (Branch) state_d = ST_BEQ;
                            else        at_boundary = 1'b1;
                        end
                        default:                                  state_d = ST_DR;
                    endcase
                end
            end
            ST_DR: begin
                ALUOp   = ALUOP_FUNC;
                ALUSrcA = 1'b1;
                {MVA, MVB, CLRA, CLRB} = IR;
                state_d = ST_DR_WRITE;
            end
            ST_IMM: begin
                ALUOp   = ALUOP_FUNC;
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = ST_DR_WRITE;
            end
            ST_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_OFFS;
                state_d = (op_legal && op4 == OP_SW) ? ST_SW_WRITE : ST_LW_READ;
            end
            ST_SW_WRITE: begin
                MemAddr  = MADDR_ALU;
                MemWrite = 1'b1;
                if (MemReady) at_boundary = 1'b1;
            end
            ST_LW_READ: begin
                MemAddr = MADDR_ALU;
                MemRead = 1'b1;
                if (MemReady) state_d = ST_LW_WRITE;
            end
            ST_LW_WRITE: begin
                RegWrite     = 1'b1;
                WriteDataSrc = 1'b1;
                at_boundary  = 1'b1;
            end
            ST_DR_WRITE, ST_JAL: begin
                RegWrite    = 1'b1;
                at_boundary = 1'b1;
            end
            ST_J: begin
                PCWrite = 1'b1;
                ALUOp   = ALUOP_PASS;
                PcIn    = PCIN_JUMP;
                // The J leg of a JR is the return-from-interrupt point.
                set_ie  = op_legal && (op4 == OP_JR);
                if (op_legal && op4 == OP_JAL) state_d = ST_JAL;
                else                           at_boundary = 1'b1;
            end
            ST_JR: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_PASS;
                {MVA, MVB, CLRA, CLRB} = IR;
                state_d = ST_J;
            end
            ST_BEQ: begin
                PCWrite     = 1'b1;
                at_boundary = 1'b1;
            end
            ST_INTERRUPT: begin
                MemWrite = 1'b1;
                MemAddr  = MADDR_VEC;
                MemData  = 1'b1;
                PcIn     = PCIN_VEC;
                if (MemReady) begin
                    PCWrite   = 1'b1;
                    IrqAck    = irq_onehot_q;
                    irq_taken = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RESET;
        endcase

        enter_irq = at_boundary && ie_q && irq_valid;
        if (at_boundary) state_d = enter_irq ? ST_INTERRUPT : ST_FETCH;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_RESET;
            ie_q         <= 1'b1;
            IrqVector    <= '0;
            irq_onehot_q <= '0;
        end else begin
            state_q <= state_n;
            if (enter_irq) begin
                IrqVector    <= irq_index;
                irq_onehot_q <= irq_onehot;
            end
            if (irq_taken)   ie_q <= 1'b0;
            else if (set_ie) ie_q <= 1'b1;
        end
    end

`ifdef CHINPO_CTRL_MEM_TIMEOUT_EN
    localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_stall, fault_trip, mem_fault_q;

    assign mem_stall  = is_mem_state(state_q) && !MemReady;
    assign fault_trip = mem_stall && (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX));
    assign state_n    = fault_trip ? ST_FAULT : state_d;
    assign MemFault   = mem_fault_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            wait_cnt_q <= (mem_stall && !fault_trip) ? wait_cnt_q + 1'b1 : '0;
            if (fault_trip) mem_fault_q <= 1'b1;
        end
    end
`else
    logic unused_wait_max;

    assign state_n         = state_d;
    assign MemFault        = 1'b0;
    assign unused_wait_max = (MEM_WAIT_MAX != 0) && is_mem_state(state_q);
`endif

endmodule

// File: tb/tb_chinpo_control_mc.sv
// tb/tb_chinpo_control_mc.sv - instruction-level reference model bench for chinpo_control_mc
module tb_chinpo_control_mc;

    localparam logic [4:0] S_RESET = 5'd0,  S_FETCH = 5'd1,  S_DECODE = 5'd2,  S_DR = 5'd3;
    localparam logic [4:0] S_IMM = 5'd4,    S_MEMADDR = 5'd5, S_BEQ = 5'd6,    S_J = 5'd7;
    localparam logic [4:0] S_JR = 5'd8,     S_DR_WRITE = 5'd9, S_SW_WRITE = 5'd10, S_LW_READ = 5'd11;
    localparam logic [4:0] S_LW_WRITE = 5'd12, S_JAL = 5'd13, S_INTERRUPT = 5'd14, S_FAULT = 5'd15;

    typedef struct {
        logic [4:0] st;
        bit         rdy;
        bit         rst;
        logic [3:0] irq;
        logic [1:0] vec;
    } cyc_t;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [4:0] Opcode = '0;
    logic       Branch = 1'b0;
    logic [3:0] IR = '0;
    logic [3:0] IrqReq = '0;
    logic       MemReady = 1'b1;
    logic PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemData, ALUSrcA, WriteDataSrc;
    logic CLRA, CLRB, MVA, MVB, MemFault;
    logic [2:0] ALUSrcB;
    logic [1:0] ALUOp, MemAddr, PcIn, IrqVector;
    logic [3:0] IrqAck;
    logic [4:0] CurrentState;

    chinpo_control_mc #(.OPCODE_W(5), .NUM_IRQ(4), .MEM_WAIT_MAX(3)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Branch(Branch), .IR(IR),
        .IrqReq(IrqReq), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemData(MemData),
        .ALUSrcA(ALUSrcA), .WriteDataSrc(WriteDataSrc), .CLRA(CLRA), .CLRB(CLRB),
        .MVA(MVA), .MVB(MVB), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemAddr(MemAddr),
        .PcIn(PcIn), .IrqAck(IrqAck), .IrqVector(IrqVector), .MemFault(MemFault),
        .CurrentState(CurrentState)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad = 0;
    cyc_t       seq[$];
    cyc_t       cur;
    bit         chk_en = 1'b0;
    bit         m_ie = 1'b1;
    logic [1:0] m_vec = '0;
    logic [4:0] cur_op = '0;
    logic       cur_br = 1'b0;
    logic [3:0] cur_ir = '0;
    logic [3:0] last_ack = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output values each state must present, straight from the state descriptions.
    function automatic logic [25:0] exp_out(input logic [4:0] st, input bit rdy,
                                            input logic [3:0] ir, input logic [1:0] vec);
        logic pcw, irw, rw, mr, mw, md, asa, wds, clra, clrb, mva, mvb, mf;
        logic [2:0] asb;
        logic [1:0] aop, madr, pcin;
        logic [3:0] ack;
        {pcw, irw, rw, mr, mw, md, asa, wds, clra, clrb, mva, mvb, mf} = '0;
        asb = '0; aop = '0; madr = '0; pcin = '0; ack = '0;
        case (st)
            S_FETCH:     begin mr = 1; asb = 4; irw = rdy; pcw = rdy; end
            S_DECODE:    asb = 3;
            S_DR:        begin aop = 2; asa = 1; {mva, mvb, clra, clrb} = ir; end
            S_IMM:       begin aop = 2; asa = 1; asb = 1; end
            S_MEMADDR:   begin asa = 1; asb = 3; end
            S_SW_WRITE:  begin madr = 1; mw = 1; end
            S_LW_READ:   begin madr = 1; mr = 1; end
            S_LW_WRITE:  begin rw = 1; wds = 1; end
            S_DR_WRITE:  rw = 1;
            S_JAL:       rw = 1;
            S_J:         begin pcw = 1; aop = 3; pcin = 1; end
            S_JR:        begin asa = 1; aop = 3; {mva, mvb, clra, clrb} = ir; end
            S_BEQ:       pcw = 1;
            S_INTERRUPT: begin
                mw = 1; madr = 3; md = 1; pcin = 3;
                if (rdy) begin pcw = 1; ack = 4'b0001 << vec; end
            end
            S_FAULT:     mf = 1;
            default:     ;
        endcase
        return {pcw, irw, rw, mr, mw, md, asa, wds, clra, clrb, mva, mvb,
                asb, aop, madr, pcin, ack, mf};
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            check("state", {27'd0, CurrentState}, {27'd0, cur.st});
            check("outputs", {6'd0, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemData,
                              ALUSrcA, WriteDataSrc, CLRA, CLRB, MVA, MVB, ALUSrcB, ALUOp,
                              MemAddr, PcIn, IrqAck, MemFault},
                  {6'd0, exp_out(cur.st, cur.rdy, cur_ir, cur.vec)});
            check("irq_vector", {30'd0, IrqVector}, {30'd0, cur.vec});
            if (IrqAck != 0) last_ack = IrqAck;
        end
    end

    task automatic push1(input logic [4:0] st, input bit rdy, input bit rst, input logic [3:0] irq);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.rst = rst; c.irq = irq; c.vec = m_vec;
        seq.push_back(c);
    endtask

    task automatic push(input logic [4:0] st, input int waits, input logic [3:0] irq);
        for (int i = 0; i <= waits; i++) push1(st, i == waits, 1'b0, irq);
    endtask

    // One instruction as a list of states; waits and the interrupt decision follow the timing rules.
    task automatic build(input logic [4:0] op, input logic br, input logic [3:0] ir,
                         input int fw, input int mw, input int iw,
                         input logic [3:0] irq_mid, input logic [3:0] irq_bnd);
        cyc_t c;
        bit   is_jr, take;
        seq.delete();
        cur_op = op; cur_br = br; cur_ir = ir;
        is_jr = 1'b0;
        push(S_FETCH, fw, irq_mid);
        push(S_DECODE, 0, irq_mid);
        if (op < 16 && !(op == 12 && !br)) begin
            case (op)
                3:             begin push(S_JR, 0, irq_mid); push(S_J, 0, irq_mid); is_jr = 1'b1; end
                4, 9, 10, 13:  begin push(S_IMM, 0, irq_mid); push(S_DR_WRITE, 0, irq_mid); end
                8:             push(S_J, 0, irq_mid);
                11:            begin push(S_J, 0, irq_mid); push(S_JAL, 0, irq_mid); end
                12:            push(S_BEQ, 0, irq_mid);
                14:            begin push(S_MEMADDR, 0, irq_mid); push(S_LW_READ, mw, irq_mid);
                                     push(S_LW_WRITE, 0, irq_mid); end
                15:            begin push(S_MEMADDR, 0, irq_mid); push(S_SW_WRITE, mw, irq_mid); end
                default:       begin push(S_DR, 0, irq_mid); push(S_DR_WRITE, 0, irq_mid); end
            endcase
        end
        c = seq.pop_back();
        c.irq = irq_bnd;
        seq.push_back(c);
        take = m_ie && (irq_bnd != 0);
        if (is_jr) m_ie = 1'b1;
        if (take) begin
            for (int i = 3; i >= 0; i--) if (irq_bnd[i]) m_vec = 2'(i);
            push(S_INTERRUPT, iw, 4'b0000);
            m_ie = 1'b0;
        end
    endtask

    task automatic run_seq();
        while (seq.size() > 0) begin
            cur = seq.pop_front();
            Reset = cur.rst; MemReady = cur.rdy; IrqReq = cur.irq;
            Opcode = cur_op; Branch = cur_br; IR = cur_ir;
            chk_en = 1'b1;
            @(posedge CLK);
            #1;
        end
        chk_en = 1'b0;
    endtask

    initial begin
        @(posedge CLK);
        #1;
        m_ie = 1'b1; m_vec = '0;
        push1(S_RESET, 1, 1, 0); push1(S_RESET, 1, 1, 0); push1(S_RESET, 1, 0, 0);
        run_seq();

        build(5'd0, 0, 4'b1010, 0, 0, 0, 0, 0);  check("len_add", seq.size(), 4); run_seq();
        build(5'd14, 0, 0, 0, 2, 0, 0, 0);       check("len_lw_w2", seq.size(), 7); run_seq();
        build(5'd15, 0, 0, 1, 0, 0, 0, 0);       check("len_sw_fw1", seq.size(), 5); run_seq();
        build(5'd8, 0, 0, 0, 0, 0, 0, 0);        check("len_j", seq.size(), 3); run_seq();
        build(5'd11, 0, 0, 0, 0, 0, 0, 0);       check("len_jal", seq.size(), 4); run_seq();
        build(5'd12, 1, 0, 0, 0, 0, 0, 0);       check("len_beq_t", seq.size(), 3); run_seq();
        build(5'd12, 0, 0, 0, 0, 0, 0, 0);       check("len_beq_nt", seq.size(), 2); run_seq();
        build(5'h13, 0, 0, 0, 0, 0, 0, 0);       check("len_wide_nop", seq.size(), 2); run_seq();
        build(5'd9, 0, 0, 0, 0, 0, 0, 0);        check("len_imm", seq.size(), 4); run_seq();

        last_ack = '0;
        build(5'd0, 0, 4'b0011, 0, 0, 1, 4'b0110, 4'b0110);
        check("len_add_irq", seq.size(), 6); run_seq();
        check("ack_literal", {28'd0, last_ack}, 32'h2);
        check("vec_literal1", {30'd0, IrqVector}, 32'h1);

        build(5'd0, 0, 0, 0, 0, 0, 4'b0001, 4'b0001); check("len_masked", seq.size(), 4); run_seq();
        build(5'd3, 0, 4'b0101, 0, 0, 0, 4'b0001, 4'b0000); check("len_jr", seq.size(), 4); run_seq();
        build(5'd12, 0, 0, 0, 0, 0, 4'b0000, 4'b0001); check("len_nop_irq", seq.size(), 3); run_seq();
        check("vec_literal0", {30'd0, IrqVector}, 32'h0);
        build(5'd3, 0, 4'b1000, 0, 0, 0, 0, 0);  run_seq();
        build(5'd0, 0, 0, 0, 0, 0, 4'b0100, 4'b0000); check("len_mid_change", seq.size(), 4); run_seq();

        // Reset landing in the middle of a store wait.
        seq.delete(); cur_op = 5'd15; cur_br = 0; cur_ir = 0;
        push(S_FETCH, 0, 0); push(S_DECODE, 0, 0); push(S_MEMADDR, 0, 0);
        push1(S_SW_WRITE, 0, 0, 0); push1(S_SW_WRITE, 0, 1, 0);
        m_ie = 1'b1; m_vec = '0;
        push1(S_RESET, 1, 0, 0);
        run_seq();
        build(5'd0, 0, 0, 0, 0, 0, 0, 4'b1000); run_seq();
        check("vec_literal3", {30'd0, IrqVector}, 32'h3);

`ifdef CHINPO_CTRL_MEM_TIMEOUT_EN
        seq.delete(); cur_op = 5'd0;
        for (int i = 0; i < 4; i++) push1(S_FETCH, 0, 0, 0);
        push1(S_FAULT, 1, 0, 4'b0001); push1(S_FAULT, 0, 0, 0); push1(S_FAULT, 1, 0, 0);
        push1(S_FAULT, 1, 1, 0);
        m_ie = 1'b1; m_vec = '0;
        push1(S_RESET, 1, 0, 0);
        check("len_timeout", seq.size(), 9);
        run_seq();
        build(5'd0, 0, 0, 0, 0, 0, 0, 0); run_seq();
`else
        build(5'd12, 0, 0, 6, 0, 0, 0, 0); check("len_long_wait", seq.size(), 8); run_seq();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
